// File: rtl/jesd204_ilas_sequence_checker_if.sv
// ---------------------------------------------------------------------------
// jesd204_ilas_sequence_checker_if
//   Decoded lane beat presented to the ILAS sequence checker.
//   Ports / signals:
//     data       DATA_PATH_WIDTH*8  beat, octet 0 in [7:0]
//     charisk28  DATA_PATH_WIDTH    per-octet K28.x flag
//   Modports:
//     master  drives the beat (8b10b decode / CGS stage, or a testbench)
//     slave   consumes the beat (the checker)
//   There is no valid/ready pair: the lane produces one beat every clock and
//   the consumer must accept it in that same cycle.
// ---------------------------------------------------------------------------
interface jesd204_ilas_sequence_checker_if #(
  parameter int DATA_PATH_WIDTH = 4
);
  logic [DATA_PATH_WIDTH*8-1:0] data;
  logic [DATA_PATH_WIDTH-1:0]   charisk28;

  modport master (output data, output charisk28);
  modport slave  (input  data, input  charisk28);
endinterface

// File: rtl/jesd204_ilas_sequence_checker.sv
// ---------------------------------------------------------------------------
// jesd204_ilas_sequence_checker
//   Per-lane JESD204B RX ILAS tracker. It follows the ILAS multiframes, checks
//   where /R/ /Q/ /A/ fall relative to the multiframe length, captures the 14
//   link-config octets of multiframe 1, and releases the elastic buffer
//   (data_ready_n low) from the first user-data beat.
//   Ports:
//     clk                        lane/device clock
//     resetn                     asynchronous active-low reset
//     restart                    sync pulse, back to IDLE (CGS re-entered)
//     cfg_octets_per_multiframe  F*K-1
//     lane                       decoded beat (data, charisk28), slave side
//     data_ready_n               0 from the first user-data beat onward
//     ilas_config                config octets 0..13, octet n in [8n+7:8n]
//     ilas_config_valid          ilas_config holds a complete capture
//     ilas_mf_count              ILAS multiframes completed (saturates at 15)
//     ilas_error                 sticky: [0] /R/ missing, [1] /Q/ missing,
//                                [2] /A/ misplaced, [3] extra ILAS MF,
//                                [4] illegal multiframe length
//     state_dbg                  current FSM state
// ---------------------------------------------------------------------------
module jesd204_ilas_sequence_checker #(
  parameter int DATA_PATH_WIDTH  = 4,
  parameter int ILAS_MULTIFRAMES = 4
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               restart,
  input  logic [9:0]                         cfg_octets_per_multiframe,
  jesd204_ilas_sequence_checker_if.slave     lane,
  output logic                               data_ready_n,
  output logic [111:0]                       ilas_config,
  output logic                               ilas_config_valid,
  output logic [3:0]                         ilas_mf_count,
  output logic [4:0]                         ilas_error,
  output logic [1:0]                         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ILAS  = 2'd1,
    S_DATA  = 2'd2,
    S_ERROR = 2'd3
  } state_e;

  localparam int         DPW_LOG2      = $clog2(DATA_PATH_WIDTH);
  localparam int         TOP           = DATA_PATH_WIDTH - 1;
  // Beat of multiframe 1 that carries MF octet 15 (last config octet).
  localparam logic [9:0] CFG_LAST_BEAT = 10'(15 / DATA_PATH_WIDTH);
  localparam logic [3:0] LAST_MF       = 4'(ILAS_MULTIFRAMES - 1);

  state_e      state;
  logic [9:0]  beat_cnt;
  logic [9:0]  beats_m1;     // BEATS-1, latched when ILAS starts
  logic        first_data;   // current beat is the first DATA beat

  logic        is_r;
  logic        is_q;
  logic        is_a;
  logic [10:0] cfg_plus1;
  logic        cfg_legal;
  logic [9:0]  beats_m1_next;
  logic        last_beat;
  logic [4:0]  ilas_err_bit;
  logic [111:0] cfg_next;
  int          cap_pos;

  assign state_dbg = state;

  assign is_r = lane.charisk28[0]   && (lane.data[7:0]        == 8'h1C);
  assign is_q = lane.charisk28[1]   && (lane.data[15:8]       == 8'h9C);
  assign is_a = lane.charisk28[TOP] && (lane.data[8*TOP +: 8] == 8'h7C);

  assign cfg_plus1     = {1'b0, cfg_octets_per_multiframe} + 11'd1;
  assign cfg_legal     = (cfg_octets_per_multiframe >= 10'd15) &&
                         (cfg_plus1[DPW_LOG2-1:0] == '0);
  assign beats_m1_next = 10'(cfg_plus1 >> DPW_LOG2) - 10'd1;
  assign last_beat     = (beat_cnt == beats_m1);

  // Only one error bit is ever recorded; checks are prioritised in order.
  always_comb begin
    ilas_err_bit = '0;
    if (beat_cnt == 10'd0 && ilas_mf_count != 4'd0 && !is_r)
      ilas_err_bit = 5'b00001;
    else if (beat_cnt == 10'd0 && ilas_mf_count == 4'd1 && !is_q)
      ilas_err_bit = 5'b00010;
    else if (last_beat != is_a)
      ilas_err_bit = 5'b00100;
  end

  // Merge the octets of this beat that land on MF positions 2..15.
  always_comb begin
    cfg_next = ilas_config;
    cap_pos  = 0;
    for (int i = 0; i < DATA_PATH_WIDTH; i++) begin
      cap_pos = int'(beat_cnt) * DATA_PATH_WIDTH + i;
      if (cap_pos >= 2 && cap_pos <= 15)
        cfg_next[(cap_pos-2)*8 +: 8] = lane.data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= S_IDLE;
      beat_cnt          <= '0;
      beats_m1          <= '0;
      first_data        <= 1'b0;
      data_ready_n      <= 1'b1;
      ilas_config       <= '0;
      ilas_config_valid <= 1'b0;
      ilas_mf_count     <= '0;
      ilas_error        <= '0;
    end else if (restart) begin
      // ilas_config is deliberately kept across a restart.
      state             <= S_IDLE;
      beat_cnt          <= '0;
      first_data        <= 1'b0;
      data_ready_n      <= 1'b1;
      ilas_config_valid <= 1'b0;
      ilas_mf_count     <= '0;
      ilas_error        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_r) begin
            if (!cfg_legal) begin
              ilas_error <= 5'b10000;
              state      <= S_ERROR;
            end else begin
              // This beat is beat 0 of MF 0.
              beats_m1 <= beats_m1_next;
              beat_cnt <= 10'd1;
              state    <= S_ILAS;
            end
          end
        end

        S_ILAS: begin
          if (ilas_err_bit != 5'b00000) begin
            ilas_error <= ilas_err_bit;
            state      <= S_ERROR;
          end else begin
            if (ilas_mf_count == 4'd1 && beat_cnt <= CFG_LAST_BEAT) begin
              ilas_config <= cfg_next;
              if (beat_cnt == CFG_LAST_BEAT)
                ilas_config_valid <= 1'b1;
            end
            if (last_beat) begin
              beat_cnt <= '0;
              if (ilas_mf_count != 4'd15)
                ilas_mf_count <= ilas_mf_count + 4'd1;
              if (ilas_mf_count == LAST_MF) begin
                state        <= S_DATA;
                data_ready_n <= 1'b0;
                first_data   <= 1'b1;
              end
            end else begin
              beat_cnt <= beat_cnt + 10'd1;
            end
          end
        end

        S_DATA: begin
          if (first_data) begin
            first_data <= 1'b0;
            // An /R/ here means the transmitter sent one ILAS MF too many.
            if (is_r) begin
              ilas_error   <= 5'b01000;
              data_ready_n <= 1'b1;
              state        <= S_ERROR;
            end
          end
        end

        default: begin
          data_ready_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jesd204_ilas_sequence_checker.sv
// ---------------------------------------------------------------------------
// tb_jesd204_ilas_sequence_checker
//   Two checkers (4- and 8-octet data paths) share clock, reset, restart and
//   cfg. The active one receives an octet stream built from ILAS rules; the
//   other sees all-zero beats. A reference model works on absolute octet
//   offsets (offset / F gives the multiframe, offset % F the position) and is
//   compared against every output after every clock.
// ---------------------------------------------------------------------------
module tb_jesd204_ilas_sequence_checker;

  localparam int ILAS_MF = 4;
  localparam int P_IDLE = 0, P_ILAS = 1, P_DATA = 2, P_ERR = 3;
  localparam logic [111:0] CFG_SEQ = 112'h0d0c0b0a09080706050403020100;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       resetn;
  logic       restart;
  logic [9:0] cfg;

  always #5 clk = ~clk;

  jesd204_ilas_sequence_checker_if #(.DATA_PATH_WIDTH(4)) if4 ();
  jesd204_ilas_sequence_checker_if #(.DATA_PATH_WIDTH(8)) if8 ();

  logic         drn4, val4, drn8, val8;
  logic [111:0] cfg4, cfg8;
  logic [3:0]   mfc4, mfc8;
  logic [4:0]   err4, err8;
  logic [1:0]   st4, st8;

  jesd204_ilas_sequence_checker #(.DATA_PATH_WIDTH(4), .ILAS_MULTIFRAMES(ILAS_MF)) dut4 (
    .clk(clk), .resetn(resetn), .restart(restart),
    .cfg_octets_per_multiframe(cfg), .lane(if4),
    .data_ready_n(drn4), .ilas_config(cfg4), .ilas_config_valid(val4),
    .ilas_mf_count(mfc4), .ilas_error(err4), .state_dbg(st4)
  );

  jesd204_ilas_sequence_checker #(.DATA_PATH_WIDTH(8), .ILAS_MULTIFRAMES(ILAS_MF)) dut8 (
    .clk(clk), .resetn(resetn), .restart(restart),
    .cfg_octets_per_multiframe(cfg), .lane(if8),
    .data_ready_n(drn8), .ilas_config(cfg8), .ilas_config_valid(val8),
    .ilas_mf_count(mfc8), .ilas_error(err8), .state_dbg(st8)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  int n_low = 0;

  task automatic check(input string tag, input logic [111:0] got, input logic [111:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- stimulus state ----------------
  int         act = 4;           // active data path width
  logic [8:0] sq[$];             // {k, octet} stream for the active checker
  logic [7:0] bo[8];
  logic       bk[8];

  // ---------------- reference model ----------------
  int           m_ph, m_nb, m_f, m_a;
  logic [4:0]   m_err;
  logic         m_val, m_drn, m_first;
  logic [111:0] m_cfg;

  task automatic model_reset();
    m_ph = P_IDLE; m_nb = 0; m_f = 0; m_a = 0;
    m_err = '0; m_val = 1'b0; m_drn = 1'b1; m_first = 1'b0; m_cfg = '0;
  endtask

  task automatic model_step(input logic r);
    int   off, mf, pos, e, p;
    logic ir, iq, ia, last;
    if (r) begin
      m_ph = P_IDLE; m_a = 0; m_err = '0; m_val = 1'b0; m_drn = 1'b1; m_first = 1'b0;
      return;
    end
    ir = bk[0] && bo[0] == 8'h1C;
    iq = bk[1] && bo[1] == 8'h9C;
    ia = bk[act-1] && bo[act-1] == 8'h7C;
    case (m_ph)
      P_IDLE: if (ir) begin
        if (int'(cfg) < 15 || (int'(cfg) + 1) % act != 0) begin
          m_err = 5'b10000; m_ph = P_ERR;
        end else begin
          m_f = int'(cfg) + 1; m_nb = 1; m_ph = P_ILAS;
        end
      end
      P_ILAS: begin
        off  = m_nb * act;
        mf   = off / m_f;
        pos  = off % m_f;
        last = (pos + act == m_f);
        e = 0;
        if (pos == 0 && mf > 0 && !ir)        e = 1;
        else if (pos == 0 && mf == 1 && !iq)  e = 2;
        else if (last != ia)                  e = 4;
        if (e != 0) begin
          m_err = 5'(e); m_ph = P_ERR;
        end else begin
          if (mf == 1) begin
            for (int i = 0; i < act; i++) begin
              p = pos + i;
              if (p >= 2 && p <= 15) m_cfg[(p-2)*8 +: 8] = bo[i];
              if (p == 15) m_val = 1'b1;
            end
          end
          if (last) begin
            if (m_a < 15) m_a++;
            if (mf == ILAS_MF - 1) begin
              m_ph = P_DATA; m_drn = 1'b0; m_first = 1'b1;
            end
          end
          m_nb++;
        end
      end
      P_DATA: if (m_first) begin
        m_first = 1'b0;
        if (ir) begin
          m_err = 5'b01000; m_drn = 1'b1; m_ph = P_ERR;
        end
      end
      default: m_drn = 1'b1;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_beat();
    logic [63:0] d;
    logic [7:0]  k;
    for (int i = 0; i < 8; i++) begin
      d[8*i +: 8] = bo[i];
      k[i]        = bk[i];
    end
    if (act == 4) begin
      if4.data = d[31:0]; if4.charisk28 = k[3:0];
      if8.data = '0;      if8.charisk28 = '0;
    end else begin
      if8.data = d;       if8.charisk28 = k;
      if4.data = '0;      if4.charisk28 = '0;
    end
  endtask

  task automatic next_beat();
    logic [8:0] v;
    for (int i = 0; i < 8; i++) begin
      if (i < act) begin
        if (sq.size() > 0) v = sq.pop_front();
        else               v = {1'b0, 8'($urandom_range(0, 255))};
      end else begin
        v = '0;
      end
      bo[i] = v[7:0];
      bk[i] = v[8];
    end
    apply_beat();
  endtask

  task automatic compare_all(input string tag);
    logic         a_drn, a_val;
    logic [111:0] a_cfg;
    logic [3:0]   a_mfc;
    logic [4:0]   a_err;
    if (act == 4) begin a_drn = drn4; a_val = val4; a_cfg = cfg4; a_mfc = mfc4; a_err = err4; end
    else          begin a_drn = drn8; a_val = val8; a_cfg = cfg8; a_mfc = mfc8; a_err = err8; end
    check({tag, ".drn"}, 112'(a_drn), 112'(m_drn));
    check({tag, ".val"}, 112'(a_val), 112'(m_val));
    check({tag, ".cfg"}, a_cfg, m_cfg);
    check({tag, ".mfc"}, 112'(a_mfc), 112'(m_a));
    check({tag, ".err"}, 112'(a_err), 112'(m_err));
    if (a_drn == 1'b0) n_low++;
  endtask

  task automatic cycle(input logic r);
    restart = r;
    next_beat();
    @(posedge clk);
    model_step(r);
    #1;
    compare_all(act == 4 ? "dp4" : "dp8");
  endtask

  task automatic run(input int n, input int restart_pct);
    for (int c = 0; c < n; c++)
      cycle(($urandom_range(0, 99) < restart_pct) ? 1'b1 : 1'b0);
    restart = 1'b0;
  endtask

  // Asynchronous reset: checked 1 time unit after assertion, before any edge.
  task automatic do_reset();
    resetn  = 1'b0;
    restart = 1'b0;
    sq.delete();
    for (int i = 0; i < 8; i++) begin bo[i] = '0; bk[i] = 1'b0; end
    apply_beat();
    #1;
    model_reset();
    compare_all("reset");
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    n_low  = 0;
  endtask

  // Idle K28.5 beats, then nmf multiframes of F octets.
  task automatic build_ilas(input int f, input int nmf, input bit rnd_cfg, input int idle_beats);
    for (int i = 0; i < idle_beats * act; i++) sq.push_back({1'b1, 8'hBC});
    for (int m = 0; m < nmf; m++) begin
      for (int j = 0; j < f; j++) begin
        if (j == 0)                          sq.push_back({1'b1, 8'h1C});
        else if (m == 1 && j == 1)           sq.push_back({1'b1, 8'h9C});
        else if (j == f - 1)                 sq.push_back({1'b1, 8'h7C});
        else if (m == 1 && j >= 2 && j <= 15)
          sq.push_back({1'b0, rnd_cfg ? 8'($urandom_range(0, 255)) : 8'(j - 2)});
        else                                 sq.push_back({1'b0, 8'($urandom_range(0, 255))});
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int f, nb, idle, nmf, idx;
    logic [7:0] sym;
    resetn = 1'b0; restart = 1'b0; cfg = 10'd31;
    model_reset();
    #12;

    // 4-octet path, four clean multiframes, config octets 0..13
    act = 4; cfg = 10'd31; do_reset();
    build_ilas(32, 4, 1'b0, 2);
    run(2 + 32 + 4, 0);
    check("t1_cfg", cfg4, CFG_SEQ);
    check("t1_val", 112'(val4), 112'(1));
    check("t1_mfc", 112'(mfc4), 112'(4));
    check("t1_err", 112'(err4), 112'(0));
    check("t1_drn", 112'(drn4), 112'(0));

    // restart in DATA, then a fresh ILAS with /Q/ replaced straight away
    cycle(1'b1);
    check("t7_drn", 112'(drn4), 112'(1));
    check("t7_err", 112'(err4), 112'(0));
    check("t7_cfg", cfg4, CFG_SEQ);
    build_ilas(32, 4, 1'b0, 1);
    sq[4 + 32 + 1] = {1'b0, 8'hAA};
    run(1 + 40, 0);
    check("t3_err", 112'(err4), 112'(5'b00010));
    check("t3_val", 112'(val4), 112'(0));
    check("t3_drn", 112'(drn4), 112'(1));

    // /A/ on beat 6 of MF 2
    do_reset();
    build_ilas(32, 4, 1'b0, 1);
    sq[4 + 2*32 + 27] = {1'b1, 8'h7C};
    run(1 + 32*4/4 + 2, 0);
    check("t4_err", 112'(err4), 112'(5'b00100));
    check("t4_mfc", 112'(mfc4), 112'(2));

    // fifth multiframe starts with /R/
    do_reset();
    build_ilas(32, 5, 1'b0, 1);
    run(1 + 40 + 4, 0);
    check("t5_err", 112'(err4), 112'(5'b01000));
    check("t5_low", 112'(n_low), 112'(1));

    // async reset in the middle of MF 1, then a clean ILAS
    do_reset();
    build_ilas(32, 4, 1'b0, 1);
    run(1 + 8 + 3, 0);
    do_reset();
    build_ilas(32, 4, 1'b0, 1);
    run(1 + 32 + 2, 0);
    check("t6_drn", 112'(drn4), 112'(0));
    check("t6_mfc", 112'(mfc4), 112'(4));

    // 8-octet path, clean
    act = 8; cfg = 10'd31; do_reset();
    build_ilas(32, 4, 1'b0, 2);
    run(2 + 16 + 3, 0);
    check("t2_cfg", cfg8, CFG_SEQ);
    check("t2_val", 112'(val8), 112'(1));
    check("t2_drn", 112'(drn8), 112'(0));

    // illegal multiframe length on the 8-octet path
    cfg = 10'd29; do_reset();
    build_ilas(30, 4, 1'b0, 1);
    run(5, 0);
    check("t8_err", 112'(err8), 112'(5'b10000));

    // randomized runs
    for (int it = 0; it < 40; it++) begin
      act = ($urandom_range(0, 1) == 0) ? 4 : 8;
      if ($urandom_range(0, 7) == 0) begin
        cfg = 10'($urandom_range(1, 100));
        f   = int'(cfg) + 1;
      end else begin
        nb  = (act == 4) ? int'($urandom_range(4, 10)) : int'($urandom_range(2, 6));
        f   = nb * act;
        cfg = 10'(f - 1);
      end
      do_reset();
      idle = int'($urandom_range(0, 3));
      nmf  = int'($urandom_range(3, 5));
      build_ilas(f, nmf, 1'b1, idle);
      if ($urandom_range(0, 1) == 1) begin
        idx = int'($urandom_range(0, sq.size() - 1));
        case ($urandom_range(0, 3))
          0:       sym = 8'h1C;
          1:       sym = 8'h9C;
          2:       sym = 8'h7C;
          default: sym = 8'($urandom_range(0, 255));
        endcase
        sq[idx] = {1'($urandom_range(0, 1)), sym};
      end
      run(sq.size() / act + 6, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
